// File: rtl/seg7_pkg.sv
// Shared definitions for the four-digit multiplexed seven-segment scanner:
// digit count, digit index type and the hex-to-segment shape table.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // Segments a..g on bits 0..6, entry n is the shape for hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [NUM_DIGITS-1:0] onehot_idx(input digit_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to seven-segment shape lookup.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit time-multiplexed seven-segment scanner with frame-synchronous
// display update, anti-ghosting gap and optional leading-zero blanking.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 12500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [15:0]           value,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      cnt_r;
  digit_idx_t            idx_r;
  logic [15:0]           pend_val_r;
  logic [NUM_DIGITS-1:0] pend_dp_r;
  logic [15:0]           disp_val_r;
  logic [NUM_DIGITS-1:0] disp_dp_r;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] digit_en_r;
  logic                  frame_done_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic [3:0]            cur_digit_s;
  logic                  blank_s;
  logic [6:0]            dec_seg_s;

  assign tick_s = en && (cnt_r == CNT_MAX);
  assign wrap_s = tick_s && (idx_r == 2'd3);

  // Slot prescaler and digit index; both freeze while scanning is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (tick_s) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else if (en) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
      idx_r <= idx_r;
    end
  end

  // Pending buffer: the most recent load wins until the next frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val_r <= 16'h0000;
      pend_dp_r  <= 4'b0000;
    end else if (load) begin
      pend_val_r <= value;
      pend_dp_r  <= dp_mask;
    end else begin
      pend_val_r <= pend_val_r;
      pend_dp_r  <= pend_dp_r;
    end
  end

  // Display content only changes at the 3->0 wrap; a coincident load bypasses pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_val_r <= 16'h0000;
      disp_dp_r  <= 4'b0000;
    end else if (wrap_s) begin
      disp_val_r <= load ? value : pend_val_r;
      disp_dp_r  <= load ? dp_mask : pend_dp_r;
    end else begin
      disp_val_r <= disp_val_r;
      disp_dp_r  <= disp_dp_r;
    end
  end

  // Select the active nibble and decide whether it is a suppressed leading zero.
  always_comb begin
    cur_digit_s = 4'h0;
    blank_s     = 1'b0;
    case (idx_r)
      2'd0: begin
        cur_digit_s = disp_val_r[3:0];
        blank_s     = 1'b0;
      end
      2'd1: begin
        cur_digit_s = disp_val_r[7:4];
        blank_s     = blank_lz && (disp_val_r[15:4] == 12'h000);
      end
      2'd2: begin
        cur_digit_s = disp_val_r[11:8];
        blank_s     = blank_lz && (disp_val_r[15:8] == 8'h00);
      end
      2'd3: begin
        cur_digit_s = disp_val_r[15:12];
        blank_s     = blank_lz && (disp_val_r[15:12] == 4'h0);
      end
      default: begin
        cur_digit_s = 4'h0;
        blank_s     = 1'b0;
      end
    endcase
  end

  seg7_decode u_decode (
    .digit (cur_digit_s),
    .seg   (dec_seg_s)
  );

  // Output stage; the tick cycle produces a dark gap so the old segments never ghost.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r        <= 7'h00;
      dp_r         <= 1'b0;
      digit_en_r   <= 4'b0000;
      frame_done_r <= 1'b0;
    end else if (!en || tick_s) begin
      seg_r        <= 7'h00;
      dp_r         <= 1'b0;
      digit_en_r   <= 4'b0000;
      frame_done_r <= wrap_s;
    end else begin
      seg_r        <= blank_s ? 7'h00 : dec_seg_s;
      dp_r         <= disp_dp_r[idx_r];
      digit_en_r   <= onehot_idx(idx_r);
      frame_done_r <= 1'b0;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign digit_en   = digit_en_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner: directed scenarios plus random traffic
// compared each cycle against a count-based reference model.
module tb_seg7_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic        en_s;
  logic [15:0] value_s;
  logic        load_s;
  logic [3:0]  dp_mask_s;
  logic        blank_lz_s;
  logic [6:0]  seg_s;
  logic        dp_s;
  logic [3:0]  digit_en_s;
  logic        frame_done_s;

  int checks_r;
  int errors_r;

  // Reference state: total enabled cycles since reset plus the two buffers.
  int          m_cnt;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  logic [15:0] m_disp;
  logic [3:0]  m_disp_dp;

  logic [6:0] hex_shape [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk_s),
    .rst        (rst_s),
    .en         (en_s),
    .value      (value_s),
    .load       (load_s),
    .dp_mask    (dp_mask_s),
    .blank_lz   (blank_lz_s),
    .seg        (seg_s),
    .dp         (dp_s),
    .digit_en   (digit_en_s),
    .frame_done (frame_done_s)
  );

  // Free-running clock.
  always #5 clk_s = ~clk_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic l,
                       input logic [15:0] v, input logic [3:0] d, input logic b);
    int         idx;
    logic [3:0] nib;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_den;
    logic       e_fd;
    rst_s = r; en_s = e; load_s = l; value_s = v; dp_mask_s = d; blank_lz_s = b;
    @(posedge clk_s);
    e_seg = 7'h00; e_dp = 1'b0; e_den = 4'b0000; e_fd = 1'b0;
    if (r) begin
      m_cnt = 0;
      m_pend = 16'h0000; m_pend_dp = 4'b0000;
      m_disp = 16'h0000; m_disp_dp = 4'b0000;
    end else begin
      idx  = (m_cnt / DIV) % 4;
      e_fd = e && ((m_cnt % FRAME) == FRAME - 1);
      if (e && ((m_cnt % DIV) != DIV - 1)) begin
        nib   = 4'((m_disp >> (4 * idx)) & 16'h000F);
        e_den = 4'(1 << idx);
        e_dp  = m_disp_dp[idx];
        e_seg = (b && idx > 0 && (m_disp >> (4 * idx)) == 16'h0000) ? 7'h00 : hex_shape[nib];
      end
      if (e) begin
        if ((m_cnt % FRAME) == FRAME - 1) begin
          m_disp    = l ? v : m_pend;
          m_disp_dp = l ? d : m_pend_dp;
        end
        m_cnt++;
      end
      if (l) begin
        m_pend    = v;
        m_pend_dp = d;
      end
    end
    #1;
    check("seg", 32'(seg_s), 32'(e_seg));
    check("dp", 32'(dp_s), 32'(e_dp));
    check("digit_en", 32'(digit_en_s), 32'(e_den));
    check("frame_done", 32'(frame_done_s), 32'(e_fd));
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000, b);
  endtask

  // Advance until the next cycle starts at the requested position within the frame.
  task automatic align(input int pos, input logic b);
    for (int i = 0; i < FRAME; i++) begin
      if ((m_cnt % FRAME) != pos) cycle(1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000, b);
    end
  endtask

  initial begin
    logic r, e, l, b;
    logic [15:0] v;
    logic [3:0] d;
    checks_r = 0;
    errors_r = 0;
    m_cnt = 0;
    m_pend = 16'h0000; m_pend_dp = 4'b0000;
    m_disp = 16'h0000; m_disp_dp = 4'b0000;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    idle(6, 1'b0);

    cycle(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0);
    idle(40, 1'b0);

    cycle(1'b0, 1'b1, 1'b1, 16'h00A5, 4'b0101, 1'b1);
    idle(40, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000, 4'b1000, 1'b1);
    idle(36, 1'b1);

    align(5, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h1111, 4'b0010, 1'b0);
    align(FRAME - 1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h2222, 4'b0100, 1'b0);
    idle(36, 1'b0);

    align(6, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0);
    idle(40, 1'b0);

    align(9, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'hBEEF, 4'b1111, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 16'hCAFE, 4'b1111, 1'b0);
    idle(40, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      d = 4'($urandom);
      b = 1'($urandom);
      cycle(r, e, l, v, d, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 12500, meaning the clk cycles per digit slot (4 kHz slot rate, 1 kHz frame rate at 50 MHz); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port en, input, 1 bit: scan enable, driven from the design-level ena.
REQ-005 The block SHALL have port value, input, 16 bits: four hex digits; digit3 = [15:12] is most significant.
REQ-006 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures value and dp_mask.
REQ-007 The block SHALL have port dp_mask, input, 4 bits: decimal point per digit; bit i lights digit i.
REQ-008 The block SHALL have port blank_lz, input, 1 bit: when 1, leading zeros are suppressed.
REQ-009 The block SHALL have port seg, output, 7 bits: segments a..g on bits 0..6, active-high, registered.
REQ-010 The block SHALL have port dp, output, 1 bit: decimal point, active-high, registered.
REQ-011 The block SHALL have port digit_en, output, 4 bits: one-hot digit select, active-high, registered.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame end, registered.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 while en=1, wrap to 0, and assert an internal tick in the cycle it equals REFRESH_DIV-1.
REQ-014 On tick, a 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-015 frame_done SHALL pulse high for exactly one cycle, one cycle after the tick that wraps the index from 3 to 0.
REQ-016 A load pulse SHALL capture value/dp_mask into a pending register; a later load before frame end SHALL overwrite the earlier one (last wins).
REQ-017 At the 3->0 wrap, the display register SHALL take the pending contents; if load coincides with that wrap tick, the display register SHALL take value/dp_mask directly (bypass), and pending SHALL take them as well.
REQ-018 The display SHALL never change content mid-frame (no tearing).
REQ-019 Outputs SHALL reflect the current index with one cycle of latency: digit_en = one-hot(index), seg = decode(display digit[index]), dp = display dp_mask[index].
REQ-020 Anti-ghosting: in the cycle after each tick, digit_en SHALL be 4'b0000, and seg and dp SHALL be 0; the new digit SHALL appear on the following cycle.
REQ-021 Decoding SHALL be full hex 0-F, standard 7-segment shapes: 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71.
REQ-022 Leading-zero blanking (blank_lz=1): digit k (k=3..1) is blanked when it and all digits above it are 0. A blanked digit SHALL drive seg=0, while digit_en and dp remain active. Digit 0 SHALL never be blanked.
REQ-023 With en=0, the prescaler and index SHALL hold, and digit_en, seg, dp and frame_done SHALL be 0. Loads SHALL still be accepted into pending.
REQ-024 When en rises, scanning SHALL resume from the held index and count.

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL clear prescaler, index, pending, display, seg, dp, digit_en and frame_done to 0.
REQ-026 Reset asserted mid-frame SHALL take priority over load and tick in the same cycle, and SHALL discard pending data.
REQ-027 After rst is released, the first tick SHALL occur REFRESH_DIV cycles later; until then digit_en SHALL be one-hot 0001, showing digit 0 of the cleared display (0x3F).

Structure
REQ-028 Shared package seg7_pkg SHALL hold NUM_DIGITS=4, the hex-to-segment constant table, and the index type.
REQ-029 Combinational sub-module seg7_decode SHALL map a 4-bit digit to 7 segments; seg7_scanner SHALL instantiate it once.
REQ-030 The prescaler width SHALL be clog2(REFRESH_DIV), with no truncation at the maximum value.

Verification (REFRESH_DIV=4)
REQ-031 Reset, then load value=0x1234, dp_mask=0 -> after the next frame wrap, digit_en cycles 0001,0010,0100,1000 with seg 0x66,0x4F,0x5B,0x06, and a zero gap cycle after each tick.
REQ-032 Load 0x00A5 with blank_lz=1 -> digits 3 and 2 show seg=0 with digit_en active; digits 1 and 0 show 0x77 and 0x6D. Load 0x0000 -> only digit 0 shows 0x3F.
REQ-033 Load 0x1111 mid-frame, then 0x2222 on the wrap tick -> no 0x1111 frame is displayed; 0x2222 is displayed from that frame on.
REQ-034 Drop en for 10 cycles mid-frame -> outputs are 0 and the index holds; on re-enable, scanning resumes at the same digit, and frame_done period = 16 cycles.
REQ-035 Assert rst during digit 2 with a pending load -> next cycle all outputs are 0; after release, 0x3F is shown and the pending value is never displayed.
